// File: rtl/reg_file_2w2r_clr.sv
// Two-write / two-read register file with optional zero register, write-to-read
// bypass and a sequential clear engine that sweeps every entry after reset or on request.
module reg_file_2w2r_clr #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  output logic              busy,
  input  logic              Write0,
  input  logic [ADDR_W-1:0] DestAddr0,
  input  logic [WIDTH-1:0]  DestData0,
  input  logic              Write1,
  input  logic [ADDR_W-1:0] DestAddr1,
  input  logic [WIDTH-1:0]  DestData1,
  input  logic [ADDR_W-1:0] AddrA,
  input  logic [ADDR_W-1:0] AddrB,
  output logic [WIDTH-1:0]  DataA,
  output logic [WIDTH-1:0]  DataB
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CLR  = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic              wrEn0;
  logic              wrEn1;

  // Address 0 is dropped as a write target when it is hard-wired to zero.
  assign wrEn0 = Write0 && !((ZERO_REG != 0) && (DestAddr0 == '0));
  assign wrEn1 = Write1 && !((ZERO_REG != 0) && (DestAddr1 == '0));

  // busy is decoded straight from the state flop, so it carries no combinational path.
  assign busy = (state == CLR);

  // Clear-sweep FSM and storage; lane 1 is assigned last so it wins on a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= CLR;
      ptr    <= '0;
      mem[0] <= '0;
    end else begin
      case (state)
        CLR: begin
          mem[ptr] <= '0;
          ptr      <= ptr + 1'b1;
          if (ptr == {ADDR_W{1'b1}}) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          if (wrEn0) begin
            mem[DestAddr0] <= DestData0;
          end
          if (wrEn1) begin
            mem[DestAddr1] <= DestData1;
          end
          if (clear) begin
            state <= CLR;
            ptr   <= '0;
          end
        end
        default: begin
          state <= CLR;
          ptr   <= '0;
        end
      endcase
    end
  end

  // Read port A: busy, zero register, lane-1 bypass, lane-0 bypass, then storage.
  always_comb begin
    DataA = '0;
    if (busy) begin
      DataA = '0;
    end else if ((ZERO_REG != 0) && (AddrA == '0)) begin
      DataA = '0;
    end else if ((BYPASS != 0) && Write1 && (DestAddr1 == AddrA)) begin
      DataA = DestData1;
    end else if ((BYPASS != 0) && Write0 && (DestAddr0 == AddrA)) begin
      DataA = DestData0;
    end else begin
      DataA = mem[AddrA];
    end
  end

  // Read port B: same priority chain as port A.
  always_comb begin
    DataB = '0;
    if (busy) begin
      DataB = '0;
    end else if ((ZERO_REG != 0) && (AddrB == '0)) begin
      DataB = '0;
    end else if ((BYPASS != 0) && Write1 && (DestAddr1 == AddrB)) begin
      DataB = DestData1;
    end else if ((BYPASS != 0) && Write0 && (DestAddr0 == AddrB)) begin
      DataB = DestData0;
    end else begin
      DataB = mem[AddrB];
    end
  end

endmodule

// File: tb/tb_reg_file_2w2r_clr.sv
// Directed bench: two instances share stimulus, one with zero register + bypass,
// one plain (ordinary entry 0, no bypass), each scenario checked with hand-computed values.
module tb_reg_file_2w2r_clr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        Write0 = 1'b0;
  logic [4:0]  DestAddr0 = 5'd0;
  logic [31:0] DestData0 = 32'd0;
  logic        Write1 = 1'b0;
  logic [4:0]  DestAddr1 = 5'd0;
  logic [31:0] DestData1 = 32'd0;
  logic [4:0]  AddrA = 5'd0;
  logic [4:0]  AddrB = 5'd0;

  logic        busyZ, busyP;
  logic [31:0] dataAZ, dataBZ, dataAP, dataBP;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_file_2w2r_clr #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dutZ (
    .clk(clk), .rst(rst), .clear(clear), .busy(busyZ),
    .Write0(Write0), .DestAddr0(DestAddr0), .DestData0(DestData0),
    .Write1(Write1), .DestAddr1(DestAddr1), .DestData1(DestData1),
    .AddrA(AddrA), .AddrB(AddrB), .DataA(dataAZ), .DataB(dataBZ)
  );

  reg_file_2w2r_clr #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) dutP (
    .clk(clk), .rst(rst), .clear(clear), .busy(busyP),
    .Write0(Write0), .DestAddr0(DestAddr0), .DestData0(DestData0),
    .Write1(Write1), .DestAddr1(DestAddr1), .DestData1(DestData1),
    .AddrA(AddrA), .AddrB(AddrB), .DataA(dataAP), .DataB(dataBP)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    clear  = 1'b0;
    Write0 = 1'b0;
    Write1 = 1'b0;
  endtask

  // Counts cycles until busy drops on both instances, bounded at 100.
  task automatic countBusy(input int already, input string name);
    int n;
    n = already;
    while ((busyZ || busyP) && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 32) begin
      failures++;
      $display("FAIL %s busy cycles got %0d expected 32", name, n);
    end
  endtask

  task automatic checkAllZero(input string name);
    for (int i = 0; i < 32; i++) begin
      AddrA = 5'(i);
      AddrB = 5'(31 - i);
      #1;
      checks++;
      if (dataAZ !== 32'd0 || dataBZ !== 32'd0 || dataAP !== 32'd0 || dataBP !== 32'd0) begin
        failures++;
        $display("FAIL %s addr %0d got Z=%h/%h P=%h/%h expected 0", name, i, dataAZ, dataBZ, dataAP, dataBP);
      end
    end
  endtask

  task automatic test_reset();
    // Power-up reset and initial sweep
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busyZ !== 1'b1 || busyP !== 1'b1 || dataAZ !== 32'd0 || dataAP !== 32'd0) begin
      failures++;
      $display("FAIL reset_state got busy=%b/%b data=%h/%h expected 1/1 0/0", busyZ, busyP, dataAZ, dataAP);
    end
    countBusy(0, "reset_sweep_initial");
    // Preload nonzero data on both lanes
    for (int k = 0; k < 16; k++) begin
      Write0 = 1'b1; DestAddr0 = 5'(2 * k);     DestData0 = 32'hC0DE0000 | 32'(2 * k);
      Write1 = 1'b1; DestAddr1 = 5'(2 * k + 1); DestData1 = 32'hC0DE0000 | 32'(2 * k + 1);
      tick();
    end
    idleInputs();
    AddrA = 5'd5;
    AddrB = 5'd0;
    #1;
    checks++;
    if (dataAP !== 32'hC0DE0005 || dataBP !== 32'hC0DE0000 || dataAZ !== 32'hC0DE0005) begin
      failures++;
      $display("FAIL preload got P=%h/%h Z=%h expected c0de0005/c0de0000 c0de0005", dataAP, dataBP, dataAZ);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    countBusy(0, "reset_sweep_preloaded");
    checkAllZero("reset_all_zero");
  endtask

  task automatic test_fill();
    for (int i = 0; i < 32; i++) begin
      Write0 = 1'b1; DestAddr0 = 5'(i); DestData0 = 32'(i);
      tick();
    end
    idleInputs();
    for (int i = 0; i < 32; i++) begin
      AddrA = 5'(i);
      AddrB = 5'(31 - i);
      #1;
      checks++;
      if (dataAZ !== ((i == 0) ? 32'd0 : 32'(i)) || dataBZ !== 32'(31 - i) ||
          dataAP !== 32'(i) || dataBP !== 32'(31 - i)) begin
        failures++;
        $display("FAIL fill addr %0d got Z=%h/%h P=%h/%h", i, dataAZ, dataBZ, dataAP, dataBP);
      end
    end
  endtask

  task automatic test_collision();
    Write0 = 1'b1; DestAddr0 = 5'd7; DestData0 = 32'hAAAA0000;
    Write1 = 1'b1; DestAddr1 = 5'd7; DestData1 = 32'h5555FFFF;
    AddrA = 5'd7;
    #1;
    checks++;
    if (dataAZ !== 32'h5555FFFF || dataAP !== 32'd7) begin
      failures++;
      $display("FAIL collision_bypass got Z=%h P=%h expected 5555ffff 00000007", dataAZ, dataAP);
    end
    tick();
    idleInputs();
    #1;
    checks++;
    if (dataAZ !== 32'h5555FFFF || dataAP !== 32'h5555FFFF) begin
      failures++;
      $display("FAIL collision_stored got Z=%h P=%h expected 5555ffff", dataAZ, dataAP);
    end
  endtask

  task automatic test_bypass();
    Write0 = 1'b1; DestAddr0 = 5'd3; DestData0 = 32'h12345678;
    AddrB = 5'd3;
    #1;
    checks++;
    if (dataBZ !== 32'h12345678 || dataBP !== 32'd3) begin
      failures++;
      $display("FAIL bypass_before got Z=%h P=%h expected 12345678 00000003", dataBZ, dataBP);
    end
    tick();
    idleInputs();
    #1;
    checks++;
    if (dataBZ !== 32'h12345678 || dataBP !== 32'h12345678) begin
      failures++;
      $display("FAIL bypass_after got Z=%h P=%h expected 12345678", dataBZ, dataBP);
    end
    // Independent lanes forwarded to separate ports
    Write0 = 1'b1; DestAddr0 = 5'd10; DestData0 = 32'h000000A0;
    Write1 = 1'b1; DestAddr1 = 5'd11; DestData1 = 32'h000000B1;
    AddrA = 5'd10;
    AddrB = 5'd11;
    #1;
    checks++;
    if (dataAZ !== 32'h000000A0 || dataBZ !== 32'h000000B1 || dataAP !== 32'd10 || dataBP !== 32'd11) begin
      failures++;
      $display("FAIL bypass_lanes got Z=%h/%h P=%h/%h", dataAZ, dataBZ, dataAP, dataBP);
    end
    tick();
    // Write to address 0: zero register wins over bypass and storage
    Write0 = 1'b0;
    Write1 = 1'b1; DestAddr1 = 5'd0; DestData1 = 32'h000000FF;
    AddrA = 5'd0;
    #1;
    checks++;
    if (dataAZ !== 32'd0 || dataAP !== 32'd0) begin
      failures++;
      $display("FAIL zero_reg_bypass got Z=%h P=%h expected 0 0", dataAZ, dataAP);
    end
    tick();
    idleInputs();
    #1;
    checks++;
    if (dataAZ !== 32'd0 || dataAP !== 32'h000000FF) begin
      failures++;
      $display("FAIL zero_reg_write got Z=%h P=%h expected 0 000000ff", dataAZ, dataAP);
    end
  endtask

  task automatic test_clear();
    clear = 1'b1;
    Write0 = 1'b1; DestAddr0 = 5'd9; DestData0 = 32'h00000099;
    tick();
    idleInputs();
    clear = 1'b1;
    Write1 = 1'b1; DestAddr1 = 5'd4; DestData1 = 32'h00000044;
    AddrA = 5'd4;
    #1;
    checks++;
    if (busyZ !== 1'b1 || busyP !== 1'b1 || dataAZ !== 32'd0 || dataAP !== 32'd0) begin
      failures++;
      $display("FAIL clear_busy_read got busy=%b/%b data=%h/%h expected 1/1 0/0", busyZ, busyP, dataAZ, dataAP);
    end
    tick();
    idleInputs();
    // Write behind the sweep pointer must also be dropped
    for (int n = 1; n < 10; n++) begin
      tick();
    end
    Write1 = 1'b1; DestAddr1 = 5'd2; DestData1 = 32'h00000022;
    tick();
    idleInputs();
    countBusy(11, "clear_sweep");
    checkAllZero("clear_all_zero");
  endtask

  task automatic test_reset_mid();
    Write0 = 1'b1; DestAddr0 = 5'd20; DestData0 = 32'hDEADBEEF;
    tick();
    idleInputs();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busyZ !== 1'b1 || busyP !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_busy got %b/%b expected 1/1", busyZ, busyP);
    end
    countBusy(0, "reset_mid_sweep");
    checkAllZero("reset_mid_all_zero");
  endtask

  initial begin
    test_reset();
    test_fill();
    test_collision();
    test_bypass();
    test_clear();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
